// File: rtl/imem_boot_loader.sv
// Boot loader: parses a length-prefixed, XOR-checksummed byte stream into 32-bit
// instruction-memory writes and releases the core reset after a good image.
// Optional inter-byte timeout enabled by defining BOOT_TIMEOUT_EN.
module imem_boot_loader #(
    parameter int ADDR_W         = 10,
    parameter int DEPTH          = 1024,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst_n,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        LEN_LO,
        LEN_HI,
        DATA,
        CSUM,
        DONE,
        ERR
    } state_t;

    localparam logic [16:0] DEPTH_L = 17'(DEPTH);

    state_t            state;
    state_t            next_state;
    logic              accept;
    logic [7:0]        len_lo;
    logic [15:0]       frame_len;
    logic [15:0]       words_left;
    logic [1:0]        byte_cnt;
    logic [23:0]       shift_reg;
    logic [ADDR_W-1:0] wr_ptr;
    logic [7:0]        csum;
    logic              word_done;
    logic              waiting;
    logic              timed_out;

    assign accept    = rx_valid && rx_ready;
    assign frame_len = {rx_data, len_lo};
    assign word_done = accept && (state == DATA) && (byte_cnt == 2'd3);
    assign waiting   = (state == LEN_HI) || (state == DATA) || (state == CSUM);

`ifdef BOOT_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] idle_cnt;

    // Idle-cycle counter only runs mid-frame; a new frame may take arbitrarily long to start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle_cnt <= '0;
        end else if (!waiting || accept) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + TO_W'(1);
        end
    end

    assign timed_out = waiting && !accept && (idle_cnt == TO_LAST);
`else
    assign timed_out = 1'b0;
`endif

    always_comb begin
        rx_ready = 1'b0;
        case (state)
            LEN_LO, LEN_HI, DATA, CSUM: rx_ready = 1'b1;
            default:                    rx_ready = 1'b0;
        endcase
    end

    always_comb begin
        next_state = state;
        case (state)
            LEN_LO: begin
                if (accept) next_state = LEN_HI;
            end
            LEN_HI: begin
                if (accept) begin
                    if ({1'b0, frame_len} > DEPTH_L) begin
                        next_state = ERR;
                    end else if (frame_len == 16'd0) begin
                        next_state = CSUM;
                    end else begin
                        next_state = DATA;
                    end
                end
            end
            DATA: begin
                if (word_done && (words_left == 16'd1)) next_state = CSUM;
            end
            CSUM: begin
                if (accept) next_state = (rx_data == csum) ? DONE : ERR;
            end
            DONE:    next_state = DONE;
            ERR:     next_state = ERR;
            default: next_state = ERR;
        endcase
        if (timed_out) next_state = ERR;
    end

    // Status outputs are registered from the next state so they rise one cycle after the deciding byte.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= LEN_LO;
            done       <= 1'b0;
            error      <= 1'b0;
            core_rst_n <= 1'b0;
        end else begin
            state      <= next_state;
            done       <= (next_state == DONE);
            error      <= (next_state == ERR);
            core_rst_n <= (next_state == DONE);
        end
    end

    // The checksum covers the count bytes and every data byte, but not the checksum byte itself.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            csum       <= 8'd0;
            len_lo     <= 8'd0;
            words_left <= 16'd0;
        end else if (accept) begin
            if (state != CSUM) csum <= csum ^ rx_data;
            if (state == LEN_LO) len_lo <= rx_data;
            if (state == LEN_HI) words_left <= frame_len;
            if (word_done) words_left <= words_left - 16'd1;
        end
    end

    // Bytes arrive LSB first, so shifting right leaves byte 0 in the low lane.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_cnt   <= 2'd0;
            shift_reg  <= 24'd0;
            wr_ptr     <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'd0;
        end else begin
            imem_we <= word_done;
            if (accept && (state == DATA)) begin
                byte_cnt <= byte_cnt + 2'd1;
                if (byte_cnt != 2'd3) begin
                    shift_reg <= {rx_data, shift_reg[23:8]};
                end else begin
                    imem_wdata <= {rx_data, shift_reg};
                    imem_addr  <= wr_ptr;
                    wr_ptr     <= wr_ptr + ADDR_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: a frame-level model predicts writes and
// the final outcome; a monitor pops expected writes whenever imem_we is seen.
module tb_imem_boot_loader;

    localparam int ADDR_W  = 4;
    localparam int DEPTH   = 12;
    localparam int TIMEOUT = 16;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = 8'd0;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_rst_n;
    logic              done;
    logic              error;

    int          checks = 0;
    int          passes = 0;
    int          cycle  = 0;
    wr_t         sb_q[$];
    int          wr_cycles[$];
    logic [7:0]  frame[$];
    logic [31:0] words[$];
    wr_t         mon_e;
    int          outcome;

    imem_boot_loader #(
        .ADDR_W(ADDR_W),
        .DEPTH(DEPTH),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx_valid(rx_valid),
        .rx_data(rx_data),
        .rx_ready(rx_ready),
        .imem_we(imem_we),
        .imem_addr(imem_addr),
        .imem_wdata(imem_wdata),
        .core_rst_n(core_rst_n),
        .done(done),
        .error(error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: every write strobe must match the oldest predicted write.
    always @(negedge clk) begin
        if (rst && imem_we) begin
            wr_cycles.push_back(cycle);
            if (sb_q.size() == 0) begin
                check_output("unexpected_write", 32'(imem_addr), 32'hFFFF_FFFF);
            end else begin
                mon_e = sb_q.pop_front();
                check_output("write_addr", 32'(imem_addr), 32'(mon_e.addr));
                check_output("write_data", imem_wdata, mon_e.data);
            end
        end
    end

    function automatic void build_frame(input logic [7:0] flip);
        logic [7:0]  x;
        logic [15:0] n;
        frame.delete();
        n = 16'(words.size());
        frame.push_back(n[7:0]);
        frame.push_back(n[15:8]);
        foreach (words[i]) begin
            for (int b = 0; b < 4; b++) frame.push_back(words[i][8*b +: 8]);
        end
        x = 8'd0;
        foreach (frame[i]) x ^= frame[i];
        frame.push_back(x ^ flip);
    endfunction

    // Frame-level reference: predicts writes completed by bytes [from,to) and the outcome after byte to-1.
    // Outcome: 0 still loading, 1 done, 2 error.
    function automatic int model(input int from, input int to);
        int         n;
        int         end_byte;
        logic [7:0] x;
        if (to < 2) return 0;
        n = int'({frame[1], frame[0]});
        if (n > DEPTH) return 2;
        for (int k = 0; k < n; k++) begin
            end_byte = 2 + 4 * k + 4;
            if (end_byte > from && end_byte <= to)
                sb_q.push_back('{ADDR_W'(k), {frame[2+4*k+3], frame[2+4*k+2], frame[2+4*k+1], frame[2+4*k]}});
        end
        if (to < 2 + 4 * n + 1) return 0;
        x = 8'd0;
        for (int i = 0; i < 2 + 4 * n; i++) x ^= frame[i];
        return (frame[2+4*n] == x) ? 1 : 2;
    endfunction

    // Sends frame bytes [from,to) with random idle gaps up to max_gap; returns on the negedge after the last accept.
    task automatic apply_stimulus(input int from, input int to, input int max_gap);
        int gap;
        for (int i = from; i < to; i++) begin
            gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            repeat (gap) begin
                @(negedge clk);
                rx_valid = 1'b0;
                rx_data  = 8'($urandom);
            end
            @(negedge clk);
            rx_valid = 1'b1;
            rx_data  = frame[i];
            check_output("rx_ready_before_byte", 32'(rx_ready), 32'd1);
            @(posedge clk);
        end
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic check_result(input int exp);
        check_output("done",       32'(done),       32'(exp == 1));
        check_output("error",      32'(error),      32'(exp == 2));
        check_output("core_rst_n", 32'(core_rst_n), 32'(exp == 1));
        check_output("rx_ready",   32'(rx_ready),   32'(exp == 0));
    endtask

    task automatic check_drained();
        @(negedge clk);
        check_output("pending_writes", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        rx_valid = 1'b0;
        sb_q.delete();
        wr_cycles.delete();
        repeat (2) @(negedge clk);
        check_output("rst_imem_we",      32'(imem_we),    32'd0);
        check_output("rst_imem_addr",    32'(imem_addr),  32'd0);
        check_output("rst_imem_wdata",   imem_wdata,      32'd0);
        check_output("rst_done_error",   32'({done, error}), 32'd0);
        check_output("rst_core_rst_n",   32'(core_rst_n), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check_output("rst_rx_ready",     32'(rx_ready),   32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reference program at full rate, then spacing of the two writes.
        do_reset();
        words = '{32'h0000_0013, 32'h0050_0093};
        build_frame(8'h00);
        outcome = model(0, frame.size());
        apply_stimulus(0, frame.size(), 0);
        check_result(outcome);
        check_drained();
        check_output("write_count", 32'(wr_cycles.size()), 32'd2);
        if (wr_cycles.size() == 2)
            check_output("write_spacing", 32'(wr_cycles[1] - wr_cycles[0]), 32'd4);

        // Corrupted checksum: words still land, load fails.
        do_reset();
        build_frame(8'h01);
        outcome = model(0, frame.size());
        apply_stimulus(0, frame.size(), 0);
        check_result(outcome);
        check_drained();

        // Empty image.
        do_reset();
        words.delete();
        build_frame(8'h00);
        outcome = model(0, frame.size());
        apply_stimulus(0, frame.size(), 0);
        check_result(outcome);
        check_drained();

        // Oversize count fails immediately after the count bytes.
        do_reset();
        frame = '{8'(DEPTH + 1), 8'h00};
        outcome = model(0, 2);
        apply_stimulus(0, 2, 0);
        check_result(outcome);
        check_drained();

        // Exactly DEPTH words is accepted.
        do_reset();
        words.delete();
        for (int i = 0; i < DEPTH; i++) words.push_back($urandom);
        build_frame(8'h00);
        outcome = model(0, frame.size());
        apply_stimulus(0, frame.size(), 0);
        check_result(outcome);
        check_drained();

        // Random gaps on an N=3 frame.
        do_reset();
        words = '{$urandom, $urandom, $urandom};
        build_frame(8'h00);
        outcome = model(0, frame.size());
        apply_stimulus(0, frame.size(), 5);
        check_result(outcome);
        check_drained();

        // Reset after 6 data bytes, then resend: writes restart at address 0.
        do_reset();
        words = '{$urandom, $urandom, $urandom};
        build_frame(8'h00);
        outcome = model(0, 8);
        apply_stimulus(0, 8, 5);
        check_result(outcome);
        check_drained();
        do_reset();
        outcome = model(0, frame.size());
        apply_stimulus(0, frame.size(), 5);
        check_result(outcome);
        check_drained();

        // Stall after 5 data bytes.
        do_reset();
        words = '{$urandom, $urandom};
        build_frame(8'h00);
        outcome = model(0, 7);
        apply_stimulus(0, 7, 0);
`ifdef BOOT_TIMEOUT_EN
        repeat (13) @(negedge clk);
        check_output("timeout_not_yet", 32'(error), 32'd0);
        repeat (6) @(negedge clk);
        check_result(2);
        check_drained();
`else
        repeat (1000) @(negedge clk);
        check_result(outcome);
        outcome = model(7, frame.size());
        apply_stimulus(7, frame.size(), 3);
        check_result(outcome);
        check_drained();
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
